// File: rtl/idu_pipe.sv
// Byte-serial decoder for a small x86 subset: walks prefix, opcode, ModR/M, SIB,
// displacement and immediate bytes over a strobe/mfc fetch handshake.
module idu_pipe #(
    parameter int unsigned ADDR_SIZE  = 32,
    parameter int unsigned MAX_PREFIX = 4,
    parameter int unsigned MAX_LEN    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] pc_in,
    input  logic                 ack,
    output logic                 strb,
    output logic                 rw,
    output logic [ADDR_SIZE-1:0] addr,
    input  logic                 mfc,
    input  logic [7:0]           data,
    output logic [2:0]           ins,
    output logic [1:0]           mod,
    output logic [2:0]           rm,
    output logic [1:0]           scale,
    output logic [2:0]           index_reg,
    output logic [2:0]           base_reg,
    output logic                 has_sib,
    output logic                 bits16,
    output logic                 s,
    output logic                 w,
    output logic                 d,
    output logic [2:0]           reg1,
    output logic [2:0]           reg2,
    output logic [31:0]          disp,
    output logic [2:0]           disp_len,
    output logic [31:0]          imm,
    output logic [2:0]           imm_len,
    output logic [2:0]           prefix_cnt,
    output logic [3:0]           ins_len,
    output logic                 rdy,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [ADDR_SIZE-1:0] pc_out
);

    typedef enum logic [2:0] {IDLE, PFX, MODRM, SIB, DISP, IMM, DONE, ERR} state_t;

    state_t                 state_q;
    logic                   strb_q, rdy_q, error_q;
    logic [1:0]             err_code_q;
    logic [ADDR_SIZE-1:0]   pc_q;
    logic [2:0]             ins_q, rm_q, index_q, base_q, reg1_q, reg2_q;
    logic [1:0]             mod_q, scale_q, cnt_q;
    logic                   has_sib_q, bits16_q, s_q, w_q, d_q;
    logic [31:0]            disp_q, imm_q;
    logic [2:0]             disp_len_q, imm_len_q, pcnt_q;
    logic [3:0]             len_q;

    logic                   is_pfx, op_valid, op_modrm, op_s, op_w, op_d, need_sib;
    logic [2:0]             op_ins, op_imm_len, wide_len, tail_dl;
    state_t                 tail_state;

    always_comb begin
        is_pfx     = data inside {8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
                                  8'h26, 8'h64, 8'h65, 8'h66};
        wide_len   = bits16_q ? 3'd2 : 3'd4;
        op_valid   = 1'b1;
        op_modrm   = 1'b0;
        op_ins     = 3'd0;
        op_imm_len = 3'd0;
        if (data[7:2] == 6'b000000) begin
            op_modrm = 1'b1;
        end else if (data == 8'h04 || data == 8'h05) begin
            op_ins     = 3'd1;
            op_imm_len = data[0] ? wide_len : 3'd1;
        end else if (data == 8'h80 || data == 8'h81 || data == 8'h83) begin
            op_ins     = 3'd2;
            op_modrm   = 1'b1;
            op_imm_len = (data == 8'h81) ? wide_len : 3'd1;
        end else if (data[7:2] == 6'b100010) begin
            op_ins   = 3'd3;
            op_modrm = 1'b1;
        end else if (data[7:4] == 4'hB) begin
            op_ins     = 3'd4;
            op_imm_len = data[3] ? wide_len : 3'd1;
        end else begin
            op_valid = 1'b0;
        end
        op_s = (op_ins == 3'd2) && data[1];
        op_d = (op_ins == 3'd0 || op_ins == 3'd3) && data[1];
        op_w = (op_ins == 3'd4) ? data[3] : data[0];

        // Displacement size depends on ModR/M alone, or on SIB base when a SIB byte follows.
        need_sib = (data[7:6] != 2'b11) && (data[2:0] == 3'b100);
        tail_dl  = 3'd0;
        if (state_q == SIB) begin
            if (mod_q == 2'b01)                              tail_dl = 3'd1;
            else if (mod_q == 2'b10)                         tail_dl = 3'd4;
            else if (mod_q == 2'b00 && data[2:0] == 3'b101)  tail_dl = 3'd4;
        end else begin
            if (data[7:6] == 2'b01)                             tail_dl = 3'd1;
            else if (data[7:6] == 2'b10)                        tail_dl = 3'd4;
            else if (data[7:6] == 2'b00 && data[2:0] == 3'b101) tail_dl = 3'd4;
        end
        if (tail_dl != 3'd0)         tail_state = DISP;
        else if (imm_len_q != 3'd0)  tail_state = IMM;
        else                         tail_state = DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;   strb_q <= 1'b0;   rdy_q <= 1'b0;     error_q <= 1'b0;
            err_code_q <= '0;  pc_q <= '0;       ins_q <= '0;       mod_q <= '0;
            rm_q <= '0;        scale_q <= '0;    index_q <= '0;     base_q <= '0;
            has_sib_q <= 1'b0; bits16_q <= 1'b0; s_q <= 1'b0;       w_q <= 1'b0;
            d_q <= 1'b0;       reg1_q <= '0;     reg2_q <= '0;      disp_q <= '0;
            disp_len_q <= '0;  imm_q <= '0;      imm_len_q <= '0;   pcnt_q <= '0;
            len_q <= '0;       cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    pc_q <= pc_in;     ins_q <= '0;      mod_q <= '0;       rm_q <= '0;
                    scale_q <= '0;     index_q <= '0;    base_q <= '0;      has_sib_q <= 1'b0;
                    bits16_q <= 1'b0;  s_q <= 1'b0;      w_q <= 1'b0;       d_q <= 1'b0;
                    reg1_q <= '0;      reg2_q <= '0;     disp_q <= '0;      disp_len_q <= '0;
                    imm_q <= '0;       imm_len_q <= '0;  pcnt_q <= '0;      len_q <= '0;
                    cnt_q <= '0;       error_q <= 1'b0;  err_code_q <= '0;
                    state_q <= PFX;
                end
                DONE: if (ack) begin
                    rdy_q   <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: if (ack) begin
                    rdy_q   <= 1'b0;
                    error_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    if (!strb_q) begin
                        if (32'(len_q) >= MAX_LEN) begin
                            state_q <= ERR; error_q <= 1'b1; rdy_q <= 1'b1; err_code_q <= 2'd2;
                        end else begin
                            strb_q <= 1'b1;
                        end
                    end else if (mfc) begin
                        strb_q <= 1'b0;
                        pc_q   <= pc_q + ADDR_SIZE'(1);
                        len_q  <= len_q + 4'd1;
                        case (state_q)
                            PFX: begin
                                if (data == 8'h67) begin
                                    state_q <= ERR; error_q <= 1'b1; rdy_q <= 1'b1; err_code_q <= 2'd3;
                                end else if (is_pfx) begin
                                    if (32'(pcnt_q) >= MAX_PREFIX) begin
                                        state_q <= ERR; error_q <= 1'b1; rdy_q <= 1'b1; err_code_q <= 2'd1;
                                    end else begin
                                        pcnt_q <= pcnt_q + 3'd1;
                                        if (data == 8'h66) bits16_q <= 1'b1;
                                    end
                                end else if (op_valid) begin
                                    ins_q <= op_ins; s_q <= op_s; w_q <= op_w; d_q <= op_d;
                                    imm_len_q <= op_imm_len;
                                    if (op_ins == 3'd4) reg1_q <= data[2:0];
                                    state_q <= op_modrm ? MODRM : IMM;
                                end else begin
                                    state_q <= ERR; error_q <= 1'b1; rdy_q <= 1'b1; err_code_q <= 2'd0;
                                end
                            end
                            MODRM: begin
                                mod_q  <= data[7:6];
                                reg1_q <= data[5:3];
                                rm_q   <= data[2:0];
                                if (data[7:6] == 2'b11) reg2_q <= data[2:0];
                                if (need_sib) begin
                                    state_q <= SIB;
                                end else begin
                                    disp_len_q <= tail_dl;
                                    state_q    <= tail_state;
                                    rdy_q      <= (tail_state == DONE);
                                end
                            end
                            SIB: begin
                                has_sib_q  <= 1'b1;
                                scale_q    <= data[7:6];
                                index_q    <= data[5:3];
                                base_q     <= data[2:0];
                                disp_len_q <= tail_dl;
                                state_q    <= tail_state;
                                rdy_q      <= (tail_state == DONE);
                            end
                            DISP: begin
                                disp_q[{cnt_q, 3'b000} +: 8] <= data;
                                if (3'(cnt_q) + 3'd1 == disp_len_q) begin
                                    cnt_q   <= '0;
                                    state_q <= (imm_len_q != 3'd0) ? IMM : DONE;
                                    rdy_q   <= (imm_len_q == 3'd0);
                                end else begin
                                    cnt_q <= cnt_q + 2'd1;
                                end
                            end
                            default: begin
                                imm_q[{cnt_q, 3'b000} +: 8] <= data;
                                if (3'(cnt_q) + 3'd1 == imm_len_q) begin
                                    cnt_q   <= '0;
                                    state_q <= DONE;
                                    rdy_q   <= 1'b1;
                                end else begin
                                    cnt_q <= cnt_q + 2'd1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign strb = strb_q;       assign rw = 1'b1;            assign addr = pc_q;
    assign pc_out = pc_q;       assign ins = ins_q;          assign mod = mod_q;
    assign rm = rm_q;           assign scale = scale_q;      assign index_reg = index_q;
    assign base_reg = base_q;   assign has_sib = has_sib_q;  assign bits16 = bits16_q;
    assign s = s_q;             assign w = w_q;              assign d = d_q;
    assign reg1 = reg1_q;       assign reg2 = reg2_q;        assign disp = disp_q;
    assign disp_len = disp_len_q;  assign imm = imm_q;       assign imm_len = imm_len_q;
    assign prefix_cnt = pcnt_q; assign ins_len = len_q;      assign rdy = rdy_q;
    assign error = error_q;     assign err_code = err_code_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: a byte-walking reference parser predicts each
// decode, a randomly stalling memory model answers fetches, a monitor compares on rdy.
module tb_idu_pipe;
    localparam int unsigned AW = 32;
    localparam int MPFX = 4;
    localparam int MLEN = 10;

    logic clk = 0, reset = 1, start = 0, ack = 0, mfc = 0;
    logic [31:0] pc_in = '0;
    logic [7:0]  data = '0;
    logic        strb, rw, has_sib, bits16, s, w, d, rdy, error;
    logic [31:0] addr, pc_out, disp, imm;
    logic [2:0]  ins, rm, index_reg, base_reg, reg1, reg2, disp_len, imm_len, prefix_cnt;
    logic [1:0]  mod, scale, err_code;
    logic [3:0]  ins_len;

    idu_pipe #(.ADDR_SIZE(AW), .MAX_PREFIX(MPFX), .MAX_LEN(MLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .ack(ack),
        .strb(strb), .rw(rw), .addr(addr), .mfc(mfc), .data(data),
        .ins(ins), .mod(mod), .rm(rm), .scale(scale), .index_reg(index_reg),
        .base_reg(base_reg), .has_sib(has_sib), .bits16(bits16), .s(s), .w(w), .d(d),
        .reg1(reg1), .reg2(reg2), .disp(disp), .disp_len(disp_len), .imm(imm),
        .imm_len(imm_len), .prefix_cnt(prefix_cnt), .ins_len(ins_len), .rdy(rdy),
        .error(error), .err_code(err_code), .pc_out(pc_out)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit err; int code; int ins, md, rm, scale, idx, base, sib, b16, s, w, d;
        int r1, r2, dl, il, pcnt, len; logic [31:0] disp, imm, pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  prog [16];
    logic [7:0]  pf [10] = '{8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65, 8'h66};
    logic [7:0]  g1 [3]  = '{8'h80, 8'h81, 8'h83};
    logic [31:0] base = '0, off;
    bit          mem_en = 1, inject = 0;
    int          nvec = 0, ncomp = 0, nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ncomp++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t fail(input exp_t e, input int code, input int n, input logic [31:0] pc);
        exp_t r = e;
        r.err = 1; r.code = code; r.len = n; r.pc = pc + 32'(n);
        return r;
    endfunction

    // Reference parser: consumes bytes in order, applying the decode rules directly.
    function automatic exp_t model(input logic [31:0] pc, input logic [7:0] p [16]);
        exp_t e;
        int n, wide, immn;
        bit mrm;
        logic [7:0] b;
        e = '{default: 0};
        n = 0; immn = 0; mrm = 0; b = '0;
        while (1) begin
            if (n >= MLEN) return fail(e, 2, n, pc);
            b = p[n]; n++;
            if (b == 8'h67) return fail(e, 3, n, pc);
            if (!(b inside {8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65, 8'h66})) break;
            if (e.pcnt == MPFX) return fail(e, 1, n, pc);
            e.pcnt++;
            if (b == 8'h66) e.b16 = 1;
        end
        wide = e.b16 ? 2 : 4;
        if (b <= 8'h03) begin
            e.ins = 0; e.d = b[1]; e.w = b[0]; mrm = 1;
        end else if (b == 8'h04 || b == 8'h05) begin
            e.ins = 1; e.w = b[0]; immn = b[0] ? wide : 1;
        end else if (b == 8'h80 || b == 8'h81 || b == 8'h83) begin
            e.ins = 2; e.s = b[1]; e.w = b[0]; mrm = 1; immn = (b == 8'h81) ? wide : 1;
        end else if (b >= 8'h88 && b <= 8'h8B) begin
            e.ins = 3; e.d = b[1]; e.w = b[0]; mrm = 1;
        end else if (b >= 8'hB0 && b <= 8'hBF) begin
            e.ins = 4; e.w = b[3]; e.r1 = b[2:0]; immn = (b >= 8'hB8) ? wide : 1;
        end else begin
            return fail(e, 0, n, pc);
        end
        e.il = immn;
        if (mrm) begin
            if (n >= MLEN) return fail(e, 2, n, pc);
            b = p[n]; n++;
            e.md = b[7:6]; e.r1 = b[5:3]; e.rm = b[2:0];
            if (e.md == 3) e.r2 = e.rm;
            e.dl = (e.md == 1) ? 1 : (e.md == 2) ? 4 : (e.md == 0 && e.rm == 5) ? 4 : 0;
            if (e.md != 3 && e.rm == 4) begin
                if (n >= MLEN) return fail(e, 2, n, pc);
                b = p[n]; n++;
                e.sib = 1; e.scale = b[7:6]; e.idx = b[5:3]; e.base = b[2:0];
                e.dl = (e.md == 1) ? 1 : (e.md == 2) ? 4 : (e.md == 0 && e.base == 5) ? 4 : 0;
            end
            for (int i = 0; i < e.dl; i++) begin
                if (n >= MLEN) return fail(e, 2, n, pc);
                b = p[n]; n++;
                e.disp = e.disp | (32'(b) << (8 * i));
            end
        end
        for (int i = 0; i < immn; i++) begin
            if (n >= MLEN) return fail(e, 2, n, pc);
            b = p[n]; n++;
            e.imm = e.imm | (32'(b) << (8 * i));
        end
        e.len = n; e.pc = pc + 32'(n);
        return e;
    endfunction

    // Memory: answers a strobe after a random stall; throws in stray mfc pulses when idle.
    initial begin
        forever begin
            @(negedge clk);
            mfc = 0; data = 8'($urandom);
            if (inject) begin
                mfc = 1; data = 8'h01;
            end else if (mem_en) begin
                if (strb) begin
                    if ($urandom_range(0, 2) != 0) begin
                        off = addr - base; mfc = 1;
                        data = (off < 16) ? prog[off[3:0]] : 8'($urandom);
                    end
                end else if ($urandom_range(0, 6) == 0) begin
                    mfc = 1;
                end
            end
        end
    end

    // Monitor: one comparison set per rising rdy.
    initial begin
        bit seen;
        exp_t e;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!rdy) seen = 0;
            else if (!seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    ncomp++; nmis++;
                    $display("FAIL unexpected_rdy: rdy=1 with empty scoreboard, required 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("error", error, e.err);
                    chk("ins_len", ins_len, e.len);
                    chk("pc_out", pc_out, e.pc);
                    if (e.err) chk("err_code", err_code, e.code);
                    else begin
                        chk("ins", ins, e.ins);       chk("mod", mod, e.md);
                        chk("rm", rm, e.rm);          chk("scale", scale, e.scale);
                        chk("index_reg", index_reg, e.idx); chk("base_reg", base_reg, e.base);
                        chk("has_sib", has_sib, e.sib);     chk("bits16", bits16, e.b16);
                        chk("s", s, e.s);             chk("w", w, e.w);
                        chk("d", d, e.d);             chk("reg1", reg1, e.r1);
                        chk("reg2", reg2, e.r2);      chk("disp", disp, e.disp);
                        chk("disp_len", disp_len, e.dl); chk("imm", imm, e.imm);
                        chk("imm_len", imm_len, e.il);   chk("prefix_cnt", prefix_cnt, e.pcnt);
                    end
                end
            end
        end
    end

    task automatic fill();
        for (int i = 0; i < 16; i++) prog[i] = 8'h90;
    endtask

    task automatic gen_rand();
        int k, np;
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        k = 0; np = $urandom_range(0, 5);
        for (int i = 0; i < np; i++) begin
            prog[k] = ($urandom_range(0, 19) == 0) ? 8'h67 : pf[$urandom_range(0, 9)];
            k++;
        end
        case ($urandom_range(0, 5))
            0: prog[k] = 8'($urandom_range(0, 5));
            1: prog[k] = g1[$urandom_range(0, 2)];
            2: prog[k] = 8'h88 + 8'($urandom_range(0, 3));
            3: prog[k] = 8'hB0 + 8'($urandom_range(0, 15));
            4: prog[k] = 8'h82;
            default: ;
        endcase
    endtask

    task automatic run_one(input logic [31:0] pc);
        exp_t e;
        int t;
        e = model(pc, prog);
        exp_q.push_back(e);
        base = pc;
        @(negedge clk); start = 1; pc_in = pc;
        t = 0;
        do begin
            @(negedge clk); t++;
            if (!rdy) begin start = 1'($urandom); ack = 1'($urandom); pc_in = $urandom; end
        end while (!rdy && t < 400);
        start = 0; ack = 0;
        if (!rdy) begin
            ncomp++; nmis++;
            $display("FAIL timeout: rdy=0 after %0d cycles, required 1", t);
            exp_q.delete();
            reset = 1; @(negedge clk); reset = 0;
        end else begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("hold_rdy", rdy, 1);
                start = 1'($urandom); pc_in = $urandom;
            end
            chk("hold_pc", pc_out, e.pc);
            start = 0; ack = 1;
            @(negedge clk); ack = 0;
            chk("rdy_clr", rdy, 0);
            chk("err_clr", error, 0);
        end
        nvec++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #12;
        chk("rst_strb", strb, 0); chk("rst_rw", rw, 1);     chk("rst_rdy", rdy, 0);
        chk("rst_error", error, 0); chk("rst_pc", pc_out, 0); chk("rst_len", ins_len, 0);
        chk("rst_disp", disp, 0); chk("rst_imm", imm, 0);
        @(negedge clk); reset = 0;

        fill(); prog[0] = 8'h01; prog[1] = 8'hD8; run_one(32'h100);
        fill(); prog[0] = 8'h66; prog[1] = 8'h81; prog[2] = 8'hC3; prog[3] = 8'h34; prog[4] = 8'h12;
        run_one(32'h200);
        fill(); prog[0] = 8'h83; prog[1] = 8'h44; prog[2] = 8'h24; prog[3] = 8'h08; prog[4] = 8'h7F;
        run_one(32'h300);
        fill(); prog[0] = 8'h8B; prog[1] = 8'h05; prog[2] = 8'h78; prog[3] = 8'h56;
        prog[4] = 8'h34; prog[5] = 8'h12; run_one(32'h400);
        fill(); for (int i = 0; i < 6; i++) prog[i] = 8'hF3; run_one(32'h500);
        fill(); prog[0] = 8'h82; run_one(32'h600);
        fill(); prog[0] = 8'h67; run_one(32'h700);
        fill(); for (int i = 0; i < 4; i++) prog[i] = 8'hF0;
        prog[4] = 8'h81; prog[5] = 8'h84; prog[6] = 8'h24; run_one(32'hFFFF_FFFC);

        repeat (150) begin
            gen_rand();
            run_one($urandom);
        end

        // Reset in the middle of a fetch, then a late mfc.
        mem_en = 0; fill(); prog[0] = 8'h01; base = 32'h2000;
        @(negedge clk); start = 1; pc_in = 32'h2000;
        @(negedge clk); start = 0;
        t = 0;
        while (!strb && t < 10) begin @(negedge clk); t++; end
        chk("strb_before_rst", strb, 1);
        #2 reset = 1;
        #1;
        chk("rst_mid_strb", strb, 0); chk("rst_mid_pc", pc_out, 0); chk("rst_mid_addr", addr, 0);
        @(negedge clk); reset = 0; inject = 1;
        @(negedge clk); inject = 0;
        repeat (2) @(negedge clk);
        chk("late_mfc_strb", strb, 0); chk("late_mfc_pc", pc_out, 0);
        chk("late_mfc_len", ins_len, 0); chk("late_mfc_rdy", rdy, 0);
        chk("late_mfc_pcnt", prefix_cnt, 0);
        nvec++;

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, meaning the width of the fetch address and program counter.
REQ-002 SHALL have parameter MAX_PREFIX, default 4, meaning the maximum number of prefix bytes accepted per instruction.
REQ-003 SHALL have parameter MAX_LEN, default 15, meaning the maximum instruction length in bytes.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk in 1, the single rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-005 SHALL have ports start in 1 (begin decode at pc_in), pc_in in ADDR_SIZE, and ack in 1 (consumer accepts the result).
REQ-006 SHALL have fetch ports strb out 1 (byte request), rw out 1 (tied 1, read), addr out ADDR_SIZE, mfc in 1 (data valid pulse) and data in 8.
REQ-007 SHALL have decode outputs ins 3, mod 2, rm 3, scale 2, index_reg 3, base_reg 3, has_sib 1, bits16 1, s 1, w 1 and d 1.
REQ-008 SHALL have decode outputs reg1 3, reg2 3, disp 32, disp_len 3, imm 32, imm_len 3, prefix_cnt 3 and ins_len 4.
REQ-009 SHALL have status outputs rdy 1, error 1, err_code 2 and pc_out ADDR_SIZE.

Function
REQ-010 SHALL implement states IDLE, PFX, MODRM, SIB, DISP, IMM, DONE and ERR.
REQ-011 Byte fetch SHALL drive strb=1 and addr=pc_out each cycle until mfc=1 is sampled; on that edge it SHALL capture data, increment pc_out and ins_len, and deassert strb the next cycle.
REQ-012 In IDLE, start=1 SHALL load pc_out=pc_in, clear all decode fields, counts and error, and enter PFX. start SHALL be ignored in all other states.
REQ-013 In PFX, bytes F0, F2, F3, 2E, 36, 3E, 26, 64, 65 and 66 SHALL be prefixes: each increments prefix_cnt, and 66 additionally sets bits16=1.
REQ-014 A prefix byte that would raise prefix_cnt above MAX_PREFIX SHALL go to ERR with err_code=1.
REQ-015 Prefix byte 67 SHALL go to ERR with err_code=3 (unsupported).
REQ-016 The opcode table SHALL be:
- 00-03: ins=0, ALU r/m,reg; d=op[1], w=op[0]; ModR/M.
- 04/05: ins=1, ALU acc,imm; w=op[0].
- 80/81/83: ins=2, grp1; s=op[1], w=op[0]; ModR/M and imm.
- 88-8B: ins=3, MOV; d, w as for 00-03; ModR/M.
- B0-BF: ins=4; w=op[3], reg1=op[2:0]; imm.
- Any other opcode, including 82: ERR with err_code=0.
REQ-017 ModR/M decode SHALL set mod=[7:6], reg1=[5:3] and rm=[2:0], with reg2=rm when mod=11.
REQ-018 When mod!=11 and rm=100, the block SHALL fetch a SIB byte: has_sib=1, scale=[7:6], index_reg=[5:3], base_reg=[2:0].
REQ-019 disp_len SHALL be 1 for mod=01; 4 for mod=10; 4 for mod=00 with rm=101; 4 for mod=00 with SIB base=101; and 0 otherwise.
REQ-020 Displacement bytes SHALL be stored little-endian into disp, with unused upper bits 0.
REQ-021 imm_len SHALL be 1 for opcodes 04, 80, 83 and B0-B7; for opcodes 05, 81 and B8-BF it SHALL be 2 if bits16=1, else 4.
REQ-022 Immediate bytes SHALL be stored little-endian into imm, with unused upper bits 0; imm SHALL NOT be sign-extended.
REQ-023 If a fetch would make ins_len exceed MAX_LEN, the block SHALL enter ERR with err_code=2 before issuing strb for that byte.
REQ-024 DONE SHALL set rdy=1 and hold all outputs stable until ack=1 is sampled; the next cycle SHALL set rdy=0 and return to IDLE.
REQ-025 ERR SHALL set rdy=1 and error=1 and obey the same ack rule; error SHALL clear on leaving ERR.
REQ-026 If ack and mfc arrive while not expected, they SHALL be ignored.
REQ-027 Minimum latency SHALL be one cycle per byte plus the mfc wait; rdy SHALL rise the cycle after the last byte is captured.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE and set every output to 0, including strb, rdy, error, pc_out and all decode fields; rw SHALL remain 1.
REQ-029 Reset mid-fetch SHALL abort the fetch, and a late mfc SHALL be ignored.

Verification
REQ-030 pc_in=0x100, bytes 01 D8 -> ins=0, mod=3, reg1=3, reg2=0, d=0, w=1, ins_len=2, pc_out=0x102, rdy=1.
REQ-031 66 81 C3 34 12 -> bits16=1, prefix_cnt=1, ins=2, reg1=0, rm=3, imm=0x1234, imm_len=2, ins_len=5.
REQ-032 83 44 24 08 7F -> has_sib=1, scale=0, index_reg=4, base_reg=4, disp=0x08, disp_len=1, imm=0x7F, imm_len=1, s=1.
REQ-033 8B 05 78 56 34 12 -> ins=3, mod=0, rm=5, disp=0x12345678, disp_len=4, d=1.
REQ-034 F3 ×5 with MAX_PREFIX=4 -> error=1, err_code=1 after the 5th byte; ack returns the block to IDLE with rdy=0.
REQ-035 Reset asserted while strb=1 -> strb=0 immediately; a subsequent mfc causes no state change.
